dummy_accelerator_arbiter: RTL and testbench

DUMMY_ACCELERATOR_ARBITER -- requirements
Module: dummy_accelerator_arbiter

---
 rtl/dummy_accelerator_arbiter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_dummy_accelerator_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_accelerator_arbiter.sv
// ---------------------------------------------------------------------------------------------
// dummy_accelerator_arbiter
//
// Arbitrates two requesters onto a single accelerator issue port. Arbitration is round-robin.
// Requests are grouped by control mode. While ops of one mode are in flight, a request of a
// different mode first drains the accelerator and only then issues. Responses are steered back
// to the issuing requester using the requester id carried in the tag MSB. They are cross-checked
// against an in-order id FIFO.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   flush_i                          synchronous clear of all in-flight bookkeeping
//   reqN_valid_i / reqN_ready_o      issue handshake from requester N (N = 0, 1)
//   reqN_ctl_i/_rs1_i/_imm_i/_tag_i  request payload of requester N
//   acc_valid_o / acc_ready_i        issue handshake toward the accelerator
//   acc_ctl_o/_rs1_o/_imm_o/_tag_o   issued payload; acc_tag_o = {requester id, tag}
//   acc_valid_i / acc_ready_o        response handshake from the accelerator
//   acc_result_i, acc_tag_i          response payload; acc_tag_i MSB selects the requester
//   respN_valid_o / respN_ready_i    response handshake toward requester N
//   respN_result_o, respN_tag_o      response payload toward requester N
//   busy_o                           high whenever the FSM is not idle
//   drain_cnt_o                      cycles spent draining (only with DUMMY_ACC_ARB_PERF_EN)
//
// Configuration macro: DUMMY_ACC_ARB_PERF_EN enables the saturating drain-cycle counter.
// Without it, drain_cnt_o is tied to zero.
// ---------------------------------------------------------------------------------------------

package dummy_acc_arb_pkg;
    typedef enum logic [1:0] {
        CtlPipeline  = 2'd0,
        CtlIterative = 2'd1,
        CtlSingle    = 2'd2,
        CtlReserved  = 2'd3
    } ctl_type_t;
endpackage

module dummy_accelerator_arbiter
    import dummy_acc_arb_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned IMM_WIDTH       = 11,
    parameter int unsigned TAG_WIDTH       = 5,
    // Power of two in 2..16 so that the FIFO pointers wrap naturally.
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,

    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  ctl_type_t            req0_ctl_i,
    input  logic [WIDTH-1:0]     req0_rs1_i,
    input  logic [IMM_WIDTH-1:0] req0_imm_i,
    input  logic [TAG_WIDTH-1:0] req0_tag_i,

    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  ctl_type_t            req1_ctl_i,
    input  logic [WIDTH-1:0]     req1_rs1_i,
    input  logic [IMM_WIDTH-1:0] req1_imm_i,
    input  logic [TAG_WIDTH-1:0] req1_tag_i,

    output logic                 acc_valid_o,
    input  logic                 acc_ready_i,
    output ctl_type_t            acc_ctl_o,
    output logic [WIDTH-1:0]     acc_rs1_o,
    output logic [IMM_WIDTH-1:0] acc_imm_o,
    output logic [TAG_WIDTH:0]   acc_tag_o,

    input  logic                 acc_valid_i,
    output logic                 acc_ready_o,
    input  logic [WIDTH-1:0]     acc_result_i,
    input  logic [TAG_WIDTH:0]   acc_tag_i,

    output logic                 resp0_valid_o,
    input  logic                 resp0_ready_i,
    output logic [WIDTH-1:0]     resp0_result_o,
    output logic [TAG_WIDTH-1:0] resp0_tag_o,

    output logic                 resp1_valid_o,
    input  logic                 resp1_ready_i,
    output logic [WIDTH-1:0]     resp1_result_o,
    output logic [TAG_WIDTH-1:0] resp1_tag_o,

    output logic                 busy_o,
    output logic [31:0]          drain_cnt_o
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_t;

    // FSM and arbitration state
    state_t    state;
    ctl_type_t cur_ctl;
    ctl_type_t pending_ctl;
    logic      prio;
    logic      locked;
    logic      lock_gnt;
    logic      busy;

    // Requester-id FIFO
    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    // Combinational issue / response signals
    logic      gnt;
    logic      gnt_valid;
    ctl_type_t gnt_ctl;
    logic      issue_ok;
    logic      issue;
    logic      resp_id;
    logic      head_match;
    logic      deliver;
    logic      resp_ready_sel;
    logic      pop;

    // ------------------------------------------------------------------
    // Grant selection. A stalled grant is held so the payload cannot move.
    // ------------------------------------------------------------------
    always_comb begin
        gnt = prio;
        if (locked) begin
            gnt = lock_gnt;
        end else if (prio == 1'b0) begin
            gnt = (!req0_valid_i && req1_valid_i) ? 1'b1 : 1'b0;
        end else begin
            gnt = (!req1_valid_i && req0_valid_i) ? 1'b0 : 1'b1;
        end
    end

    assign gnt_valid = gnt ? req1_valid_i : req0_valid_i;
    assign gnt_ctl   = gnt ? req1_ctl_i   : req0_ctl_i;

    always_comb begin
        issue_ok = 1'b0;
        unique case (state)
            StIdle:  issue_ok = 1'b1;
            StRun:   issue_ok = (gnt_ctl == cur_ctl);
            default: issue_ok = 1'b0;
        endcase
    end

    assign acc_valid_o  = gnt_valid && issue_ok && (count < MAX_CNT) && !flush_i && !rst_i;
    assign issue        = acc_valid_o && acc_ready_i;
    assign req0_ready_o = issue && !gnt;
    assign req1_ready_o = issue && gnt;

    // Payload is zeroed whenever nothing is being offered.
    always_comb begin
        acc_ctl_o = CtlPipeline;
        acc_rs1_o = '0;
        acc_imm_o = '0;
        acc_tag_o = '0;
        if (acc_valid_o) begin
            acc_ctl_o = gnt_ctl;
            acc_rs1_o = gnt ? req1_rs1_i : req0_rs1_i;
            acc_imm_o = gnt ? req1_imm_i : req0_imm_i;
            acc_tag_o = {gnt, (gnt ? req1_tag_i : req0_tag_i)};
        end
    end

    // ------------------------------------------------------------------
    // Response routing. Responses not matching the FIFO head are accepted
    // and dropped without touching the bookkeeping.
    // ------------------------------------------------------------------
    assign resp_id        = acc_tag_i[TAG_WIDTH];
    assign head_match     = (count != '0) && (id_fifo[rd_ptr] == resp_id);
    assign deliver        = acc_valid_i && head_match && !flush_i && !rst_i;
    assign resp_ready_sel = resp_id ? resp1_ready_i : resp0_ready_i;
    assign acc_ready_o    = acc_valid_i && (!deliver || resp_ready_sel);
    assign pop            = deliver && resp_ready_sel;

    assign resp0_valid_o  = deliver && !resp_id;
    assign resp1_valid_o  = deliver && resp_id;
    assign resp0_result_o = resp0_valid_o ? acc_result_i : '0;
    assign resp1_result_o = resp1_valid_o ? acc_result_i : '0;
    assign resp0_tag_o    = resp0_valid_o ? acc_tag_i[TAG_WIDTH-1:0] : '0;
    assign resp1_tag_o    = resp1_valid_o ? acc_tag_i[TAG_WIDTH-1:0] : '0;

    // ------------------------------------------------------------------
    // Requester-id FIFO; count tracks occupancy (in-flight ops).
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (issue) begin
                id_fifo[wr_ptr] <= gnt;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (issue && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !issue) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM, round-robin pointer and grant lock.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= StIdle;
            cur_ctl     <= CtlPipeline;
            pending_ctl <= CtlPipeline;
            prio        <= 1'b0;
            locked      <= 1'b0;
            lock_gnt    <= 1'b0;
            busy        <= 1'b0;
        end else if (flush_i) begin
            state  <= StIdle;
            prio   <= 1'b0;
            locked <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (issue) begin
                prio   <= ~gnt;
                locked <= 1'b0;
            end else if (acc_valid_o) begin
                locked   <= 1'b1;
                lock_gnt <= gnt;
            end

            unique case (state)
                StIdle: begin
                    if (issue) begin
                        cur_ctl <= gnt_ctl;
                        state   <= StRun;
                        busy    <= 1'b1;
                    end
                end
                StRun: begin
                    if (gnt_valid && (gnt_ctl != cur_ctl)) begin
                        // Mode change: hold the new mode until the accelerator is empty.
                        pending_ctl <= gnt_ctl;
                        state       <= StDrain;
                    end else if ((count == '0) && !req0_valid_i && !req1_valid_i) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StDrain: begin
                    if (count == '0) begin
                        cur_ctl <= pending_ctl;
                        state   <= StRun;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy;

`ifdef DUMMY_ACC_ARB_PERF_EN
    logic [31:0] drain_cnt;

    // Saturating; flush intentionally leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cnt <= '0;
        end else if ((state == StDrain) && (drain_cnt != 32'hFFFF_FFFF)) begin
            drain_cnt <= drain_cnt + 32'd1;
        end
    end

    assign drain_cnt_o = drain_cnt;
`else
    assign drain_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dummy_accelerator_arbiter.sv
// Scoreboard bench for dummy_accelerator_arbiter: stimulus pushes expected issues/responses,
// an independent negedge monitor pops and compares on every DUT handshake.
module tb_dummy_accelerator_arbiter;
    import dummy_acc_arb_pkg::*;

    logic        clk;
    logic        rst_i, flush_i;
    logic        req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
    ctl_type_t   req0_ctl_i, req1_ctl_i, acc_ctl_o;
    logic [31:0] req0_rs1_i, req1_rs1_i, acc_rs1_o;
    logic [10:0] req0_imm_i, req1_imm_i, acc_imm_o;
    logic [4:0]  req0_tag_i, req1_tag_i, resp0_tag_o, resp1_tag_o;
    logic        acc_valid_o, acc_ready_i, acc_valid_i, acc_ready_o;
    logic [5:0]  acc_tag_o, acc_tag_i;
    logic [31:0] acc_result_i, resp0_result_o, resp1_result_o;
    logic        resp0_valid_o, resp0_ready_i, resp1_valid_o, resp1_ready_i;
    logic        busy_o;
    logic [31:0] drain_cnt_o;

    typedef struct packed {
        logic [5:0]  tag;
        ctl_type_t   ctl;
        logic [31:0] rs1;
        logic [10:0] imm;
    } iss_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  tag;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp0_q[$];
    rsp_t rsp1_q[$];

    int n_vec = 0;
    int n_bad = 0;

    dummy_accelerator_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .req0_valid_i   (req0_valid_i),
        .req0_ready_o   (req0_ready_o),
        .req0_ctl_i     (req0_ctl_i),
        .req0_rs1_i     (req0_rs1_i),
        .req0_imm_i     (req0_imm_i),
        .req0_tag_i     (req0_tag_i),
        .req1_valid_i   (req1_valid_i),
        .req1_ready_o   (req1_ready_o),
        .req1_ctl_i     (req1_ctl_i),
        .req1_rs1_i     (req1_rs1_i),
        .req1_imm_i     (req1_imm_i),
        .req1_tag_i     (req1_tag_i),
        .acc_valid_o    (acc_valid_o),
        .acc_ready_i    (acc_ready_i),
        .acc_ctl_o      (acc_ctl_o),
        .acc_rs1_o      (acc_rs1_o),
        .acc_imm_o      (acc_imm_o),
        .acc_tag_o      (acc_tag_o),
        .acc_valid_i    (acc_valid_i),
        .acc_ready_o    (acc_ready_o),
        .acc_result_i   (acc_result_i),
        .acc_tag_i      (acc_tag_i),
        .resp0_valid_o  (resp0_valid_o),
        .resp0_ready_i  (resp0_ready_i),
        .resp0_result_o (resp0_result_o),
        .resp0_tag_o    (resp0_tag_o),
        .resp1_valid_o  (resp1_valid_o),
        .resp1_ready_i  (resp1_ready_i),
        .resp1_result_o (resp1_result_o),
        .resp1_tag_o    (resp1_tag_o),
        .busy_o         (busy_o),
        .drain_cnt_o    (drain_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drv0(input logic v, input ctl_type_t c, input logic [31:0] rs1,
                        input logic [10:0] imm, input logic [4:0] tag);
        req0_valid_i = v; req0_ctl_i = c; req0_rs1_i = rs1; req0_imm_i = imm; req0_tag_i = tag;
    endtask

    task automatic drv1(input logic v, input ctl_type_t c, input logic [31:0] rs1,
                        input logic [10:0] imm, input logic [4:0] tag);
        req1_valid_i = v; req1_ctl_i = c; req1_rs1_i = rs1; req1_imm_i = imm; req1_tag_i = tag;
    endtask

    task automatic rsp(input logic v, input logic id, input logic [4:0] tag,
                       input logic [31:0] res);
        acc_valid_i = v; acc_tag_i = {id, tag}; acc_result_i = res;
    endtask

    task automatic e_iss(input logic id, input logic [4:0] tag, input ctl_type_t c,
                         input logic [31:0] rs1, input logic [10:0] imm);
        iss_q.push_back(iss_t'{tag: {id, tag}, ctl: c, rs1: rs1, imm: imm});
    endtask

    task automatic e_rsp(input logic id, input logic [31:0] res, input logic [4:0] tag);
        if (id) rsp1_q.push_back(rsp_t'{result: res, tag: tag});
        else    rsp0_q.push_back(rsp_t'{result: res, tag: tag});
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) nxt();
    endtask

    // Monitor: every handshake the DUT completes must match the head of its queue.
    initial begin
        iss_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (acc_valid_o && acc_ready_i) begin
                if (iss_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_issue: got tag %0h, required no issue", acc_tag_o);
                end else begin
                    e = iss_q.pop_front();
                    chk("iss_tag", acc_tag_o, e.tag);
                    chk("iss_ctl", acc_ctl_o, e.ctl);
                    chk("iss_rs1", acc_rs1_o, e.rs1);
                    chk("iss_imm", acc_imm_o, e.imm);
                end
            end
            if (resp0_valid_o && resp0_ready_i) begin
                if (rsp0_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_resp0: got %0h, required none", resp0_result_o);
                end else begin
                    r = rsp0_q.pop_front();
                    chk("resp0_result", resp0_result_o, r.result);
                    chk("resp0_tag", resp0_tag_o, r.tag);
                end
            end
            if (resp1_valid_o && resp1_ready_i) begin
                if (rsp1_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_resp1: got %0h, required none", resp1_result_o);
                end else begin
                    r = rsp1_q.pop_front();
                    chk("resp1_result", resp1_result_o, r.result);
                    chk("resp1_tag", resp1_tag_o, r.tag);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; acc_ready_i = 1'b0;
        resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;
        drv0(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        drv1(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        rsp(1'b0, 1'b0, 5'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        mid();
        chk("rst_acc_valid", acc_valid_o, 0);
        chk("rst_req0_ready", req0_ready_o, 0);
        chk("rst_req1_ready", req1_ready_o, 0);
        chk("rst_resp0_valid", resp0_valid_o, 0);
        chk("rst_resp1_valid", resp1_valid_o, 0);
        chk("rst_acc_ready", acc_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_drain_cnt", drain_cnt_o, 0);
        chk("rst_acc_tag", acc_tag_o, 0);
        chk("rst_acc_rs1", acc_rs1_o, 0);
        chk("rst_resp0_result", resp0_result_o, 0);
        nxt();

        // Round-robin: both valid, same ctl -> grants 0,1,0,1
        acc_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv0(1'b1, CtlPipeline, 32'h100 + k, 11'h011, 5'd3);
            drv1(1'b1, CtlPipeline, 32'h200 + k, 11'h022, 5'd7);
            if (k % 2 == 0) e_iss(1'b0, 5'd3, CtlPipeline, 32'h100 + k, 11'h011);
            else            e_iss(1'b1, 5'd7, CtlPipeline, 32'h200 + k, 11'h022);
            mid();
            chk("rr_req0_ready", req0_ready_o, (k % 2 == 0));
            chk("rr_req1_ready", req1_ready_o, (k % 2 == 1));
            nxt();
        end
        drv0(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        drv1(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        for (int k = 0; k < 4; k++) begin
            rsp(1'b1, k[0], k[0] ? 5'd7 : 5'd3, 32'hA0 + k);
            e_rsp(k[0], 32'hA0 + k, k[0] ? 5'd7 : 5'd3);
            mid();
            nxt();
        end
        rsp(1'b0, 1'b0, 5'h0, 32'h0);
        idle(2);
        mid();
        chk("rr_idle_busy", busy_o, 0);
        nxt();

        // Stall: req1 granted, acc not ready, req0 arrives -> grant and payload held
        acc_ready_i = 1'b0;
        drv1(1'b1, CtlPipeline, 32'h555, 11'h033, 5'd9);
        mid();
        chk("stall_acc_valid", acc_valid_o, 1);
        chk("stall_acc_tag", acc_tag_o, 6'h29);
        nxt();
        for (int k = 0; k < 3; k++) begin
            drv0(1'b1, CtlPipeline, 32'h666, 11'h044, 5'd4);
            mid();
            chk("lock_acc_valid", acc_valid_o, 1);
            chk("lock_acc_tag", acc_tag_o, 6'h29);
            chk("lock_acc_rs1", acc_rs1_o, 32'h555);
            chk("lock_acc_imm", acc_imm_o, 11'h033);
            chk("lock_req0_ready", req0_ready_o, 0);
            nxt();
        end
        acc_ready_i = 1'b1;
        e_iss(1'b1, 5'd9, CtlPipeline, 32'h555, 11'h033);
        mid();
        chk("unlock_req1_ready", req1_ready_o, 1);
        nxt();
        drv1(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        e_iss(1'b0, 5'd4, CtlPipeline, 32'h666, 11'h044);
        mid();
        chk("after_lock_req0_ready", req0_ready_o, 1);
        nxt();
        drv0(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);

        // Backpressure on response path
        rsp(1'b1, 1'b1, 5'd9, 32'hB1);
        e_rsp(1'b1, 32'hB1, 5'd9);
        mid();
        nxt();
        resp0_ready_i = 1'b0;
        rsp(1'b1, 1'b0, 5'd4, 32'hB0);
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("hold_acc_ready", acc_ready_o, 0);
            chk("hold_resp0_valid", resp0_valid_o, 1);
            chk("hold_resp0_result", resp0_result_o, 32'hB0);
            nxt();
        end
        resp0_ready_i = 1'b1;
        e_rsp(1'b0, 32'hB0, 5'd4);
        mid();
        chk("release_acc_ready", acc_ready_o, 1);
        nxt();
        rsp(1'b0, 1'b0, 5'h0, 32'h0);
        idle(2);

        // Outstanding limit, then simultaneous issue+response
        for (int k = 0; k < 10; k++) begin
            drv0(1'b1, CtlPipeline, 32'h300 + k, 11'h055, 5'd2);
            if (k < 4 || k == 7 || k == 8) e_iss(1'b0, 5'd2, CtlPipeline, 32'h300 + k, 11'h055);
            if (k == 6 || k == 7) begin
                rsp(1'b1, 1'b0, 5'd2, 32'hC0 + k);
                e_rsp(1'b0, 32'hC0 + k, 5'd2);
            end else begin
                rsp(1'b0, 1'b0, 5'h0, 32'h0);
            end
            mid();
            chk("limit_acc_valid", acc_valid_o, (k < 4 || k == 7 || k == 8));
            nxt();
        end
        drv0(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        rsp(1'b1, 1'b0, 5'd2, 32'hC2);
        e_rsp(1'b0, 32'hC2, 5'd2);
        mid();
        nxt();

        // Flush with 3 in flight
        flush_i = 1'b1;
        drv0(1'b1, CtlPipeline, 32'h30B, 11'h055, 5'd2);
        rsp(1'b1, 1'b0, 5'd2, 32'hDD);
        mid();
        chk("flush_acc_valid", acc_valid_o, 0);
        chk("flush_resp0_valid", resp0_valid_o, 0);
        chk("flush_acc_ready", acc_ready_o, 1);
        nxt();
        flush_i = 1'b0;
        drv0(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        rsp(1'b1, 1'b0, 5'd2, 32'hDE);
        mid();
        chk("post_flush_busy", busy_o, 0);
        chk("late_resp0_valid", resp0_valid_o, 0);
        chk("late_acc_ready0", acc_ready_o, 1);
        nxt();
        rsp(1'b1, 1'b1, 5'd5, 32'hDF);
        mid();
        chk("late_resp1_valid", resp1_valid_o, 0);
        chk("late_acc_ready1", acc_ready_o, 1);
        nxt();
        rsp(1'b0, 1'b0, 5'h0, 32'h0);
        // Full capacity available again after flush
        for (int j = 0; j < 5; j++) begin
            drv0(1'b1, CtlPipeline, 32'h400 + j, 11'h055, 5'd2);
            if (j < 4) e_iss(1'b0, 5'd2, CtlPipeline, 32'h400 + j, 11'h055);
            mid();
            chk("refill_acc_valid", acc_valid_o, (j < 4));
            nxt();
        end

        // Reset mid-transaction
        rst_i = 1'b1;
        rsp(1'b1, 1'b0, 5'd2, 32'hEE);
        mid();
        chk("midrst_resp0_valid", resp0_valid_o, 0);
        chk("midrst_acc_valid", acc_valid_o, 0);
        nxt();
        drv0(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        rsp(1'b0, 1'b0, 5'h0, 32'h0);
        nxt();
        rst_i = 1'b0;
        mid();
        chk("postrst_busy", busy_o, 0);
        chk("postrst_acc_valid", acc_valid_o, 0);
        chk("postrst_acc_ready", acc_ready_o, 0);
        chk("postrst_drain_cnt", drain_cnt_o, 0);
        nxt();

        // Mode change: two ITERATIVE in flight, then PIPELINE request drains first
        drv0(1'b1, CtlIterative, 32'h700, 11'h066, 5'd6);
        e_iss(1'b0, 5'd6, CtlIterative, 32'h700, 11'h066);
        mid();
        nxt();
        drv0(1'b1, CtlIterative, 32'h701, 11'h066, 5'd6);
        e_iss(1'b0, 5'd6, CtlIterative, 32'h701, 11'h066);
        mid();
        nxt();
        drv0(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        drv1(1'b1, CtlPipeline, 32'h800, 11'h077, 5'd8);
        mid();
        chk("switch_acc_valid", acc_valid_o, 0);
        nxt();
        rsp(1'b1, 1'b0, 5'd6, 32'hF0);
        e_rsp(1'b0, 32'hF0, 5'd6);
        mid();
        chk("drain_acc_valid0", acc_valid_o, 0);
        chk("drain_busy", busy_o, 1);
        nxt();
        rsp(1'b1, 1'b0, 5'd6, 32'hF1);
        e_rsp(1'b0, 32'hF1, 5'd6);
        mid();
        chk("drain_acc_valid1", acc_valid_o, 0);
        nxt();
        rsp(1'b0, 1'b0, 5'h0, 32'h0);
        mid();
        chk("drain_acc_valid2", acc_valid_o, 0);
        nxt();
        e_iss(1'b1, 5'd8, CtlPipeline, 32'h800, 11'h077);
        mid();
        chk("resume_acc_valid", acc_valid_o, 1);
        chk("resume_acc_ctl", acc_ctl_o, CtlPipeline);
        nxt();
        drv1(1'b0, CtlPipeline, 32'h0, 11'h0, 5'h0);
        rsp(1'b1, 1'b1, 5'd8, 32'hF8);
        e_rsp(1'b1, 32'hF8, 5'd8);
        mid();
`ifdef DUMMY_ACC_ARB_PERF_EN
        chk("drain_cnt", drain_cnt_o, 3);
`else
        chk("drain_cnt", drain_cnt_o, 0);
`endif
        nxt();
        rsp(1'b0, 1'b0, 5'h0, 32'h0);
        idle(3);

        mid();
        chk("end_busy", busy_o, 0);
        chk("iss_q_left", iss_q.size(), 0);
        chk("rsp0_q_left", rsp0_q.size(), 0);
        chk("rsp1_q_left", rsp1_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
